gf180mcu_osu_sc_gp9t3v3__subs_seq: RTL and testbench

//   Bit-serial, LSB-first subtractor: computes Y = A - B - BIN one bit per clock.

---
 rtl/gf180mcu_osu_sc_gp9t3v3__subs_seq_subh.sv | 12 +
 rtl/gf180mcu_osu_sc_gp9t3v3__subs_seq.sv | 80 ++++++++
 tb/tb_gf180mcu_osu_sc_gp9t3v3__subs_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gf180mcu_osu_sc_gp9t3v3__subs_seq_subh.sv
// Half subtractor: difference and borrow-out of A - B.
module gf180mcu_osu_sc_gp9t3v3__subh_1 (
  input  logic A,
  input  logic B,
  output logic D,
  output logic BO
);

  assign D  = A ^ B;
  assign BO = ~A & B;

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__subs_seq.sv
// Bit-serial LSB-first subtractor: Y = A - B - BIN, one bit per clock.
// Operands are loaded in parallel on START, and the result appears in parallel at DONE.
module gf180mcu_osu_sc_gp9t3v3__subs_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             BOUT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra, rb;
  logic             br;
  logic [CW-1:0]    cnt;

  logic d1, bo1, d, bo2, br_next;

  // Full-subtract stage built from two half subtractors.
  gf180mcu_osu_sc_gp9t3v3__subh_1 u_hs0 (.A(ra[0]), .B(rb[0]), .D(d1), .BO(bo1));
  gf180mcu_osu_sc_gp9t3v3__subh_1 u_hs1 (.A(d1),    .B(br),    .D(d),  .BO(bo2));

  assign br_next = bo1 | bo2;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      ra    <= '0;
      rb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Y     <= '0;
      BOUT  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          ra    <= A;
          rb    <= B;
          br    <= BIN;
          Y     <= '0;
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          br <= br_next;
          ra <= ra >> 1;
          rb <= rb >> 1;
          Y  <= {d, Y[WIDTH-1:1]};
          // The counter stops at the last bit; the next START clears it.
          if (cnt == LAST) begin
            state <= S_DONE;
            BOUT  <= br_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded from the state flops only, so inputs never reach these outputs combinationally.
  assign BUSY = (state == S_RUN) || (state == S_DONE);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__subs_seq.sv
// Directed and random checks of the serial subtractor at WIDTH 8, 2 and 32.
module tb_gf180mcu_osu_sc_gp9t3v3__subs_seq;

  logic clk = 1'b0;
  logic rn;
  always #5 clk = ~clk;

  logic        st8, bin8, busy8, done8, bout8;
  logic [7:0]  a8, b8, y8;
  logic        st2, bin2, busy2, done2, bout2;
  logic [1:0]  a2, b2, y2;
  logic        st32, bin32, busy32, done32, bout32;
  logic [31:0] a32, b32, y32;

  gf180mcu_osu_sc_gp9t3v3__subs_seq #(.WIDTH(8)) u8 (
    .CLK(clk), .RN(rn), .START(st8), .A(a8), .B(b8), .BIN(bin8),
    .BUSY(busy8), .DONE(done8), .Y(y8), .BOUT(bout8));
  gf180mcu_osu_sc_gp9t3v3__subs_seq #(.WIDTH(2)) u2 (
    .CLK(clk), .RN(rn), .START(st2), .A(a2), .B(b2), .BIN(bin2),
    .BUSY(busy2), .DONE(done2), .Y(y2), .BOUT(bout2));
  gf180mcu_osu_sc_gp9t3v3__subs_seq #(.WIDTH(32)) u32 (
    .CLK(clk), .RN(rn), .START(st32), .A(a32), .B(b32), .BIN(bin32),
    .BUSY(busy32), .DONE(done32), .Y(y32), .BOUT(bout32));

  int checks = 0;
  int errors = 0;
  logic lb [0:2];

  function automatic int idx(input int s);
    return (s == 2) ? 0 : (s == 8) ? 1 : 2;
  endfunction

  function automatic logic obs_done(input int s);
    case (s) 2: return done2; 32: return done32; default: return done8; endcase
  endfunction

  function automatic logic obs_busy(input int s);
    case (s) 2: return busy2; 32: return busy32; default: return busy8; endcase
  endfunction

  function automatic logic [32:0] obs_res(input int s);
    case (s)
      2:       return {bout2, 30'd0, y2};
      32:      return {bout32, y32};
      default: return {bout8, 24'd0, y8};
    endcase
  endfunction

  task automatic drive(input int s, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic bin);
    case (s)
      2:       begin st2 = st;  a2 = a[1:0];  b2 = b[1:0];  bin2 = bin;  end
      32:      begin st32 = st; a32 = a;      b32 = b;      bin32 = bin; end
      default: begin st8 = st;  a8 = a[7:0];  b8 = b[7:0];  bin8 = bin;  end
    endcase
  endtask

  task automatic chk(input string tag, input logic [32:0] o, input logic [32:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One operation from START to DONE; exp is {BOUT, Y zero-extended}.
  task automatic op(input int s, input logic [31:0] a, input logic [31:0] b, input logic bin,
                    input logic [32:0] exp, input bit inject, input string tag);
    int cyc;
    @(negedge clk);
    drive(s, 1'b1, a, b, bin);
    @(posedge clk); #1;
    drive(s, 1'b0, a, b, bin);
    chk({tag, " busy_after_start"}, 33'(obs_busy(s)), 33'd1);
    // Y clears on START while BOUT keeps the previous result.
    chk({tag, " bout_held_y_clr"}, obs_res(s), {lb[idx(s)], 32'd0});
    cyc = 0;
    while (!obs_done(s) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (inject && cyc == 3) drive(s, 1'b1, ~a, ~b, ~bin);
      else if (inject && cyc == 4) drive(s, 1'b0, a, b, bin);
    end
    chk({tag, " latency"}, 33'(cyc), 33'(s));
    chk({tag, " result"}, obs_res(s), exp);
    lb[idx(s)] = exp[32];
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, {31'd0, obs_done(s), obs_busy(s)}, 33'd0);
  endtask

  initial begin
    logic [31:0] ra, rbv;
    logic        rbin;
    logic [2:0]  e2;
    logic [32:0] e32;

    rn = 1'b0;
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0);
    drive(32, 1'b0, 0, 0, 1'b0);
    lb[0] = 1'b0; lb[1] = 1'b0; lb[2] = 1'b0;
    #12;
    chk("reset_state8", {busy8, done8, bout8, 22'd0, y8}, 33'd0);
    chk("reset_state32", {busy32, done32, bout32, y32[29:0]}, 33'd0);
    @(negedge clk); rn = 1'b1;

    // Basic and borrow cases
    op(8, 32'h05, 32'h03, 1'b0, {1'b0, 32'h02}, 1'b0, "t1_05m03");
    op(8, 32'h03, 32'h05, 1'b0, {1'b1, 32'hFE}, 1'b0, "t2_03m05");
    op(8, 32'h00, 32'h00, 1'b1, {1'b1, 32'hFF}, 1'b0, "t2_00m00b1");
    op(8, 32'hFF, 32'h00, 1'b0, {1'b0, 32'hFF}, 1'b0, "t3_FFm00");
    op(8, 32'h80, 32'h7F, 1'b0, {1'b0, 32'h01}, 1'b0, "t3_80m7F");

    // A START during RUN with other operands must be ignored
    op(8, 32'h03, 32'h05, 1'b0, {1'b1, 32'hFE}, 1'b1, "t4_ignore_start");
    @(posedge clk); #1;
    chk("t4_no_queued_op", {31'd0, busy8, done8}, 33'd0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    drive(8, 1'b1, 32'h10, 32'h01, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'h10, 32'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_midrun_busy", 33'(busy8), 33'd1);
    rn = 1'b0;
    #1;
    chk("t5_async_reset", {busy8, done8, bout8, 22'd0, y8}, 33'd0);
    lb[0] = 1'b0; lb[1] = 1'b0; lb[2] = 1'b0;
    @(negedge clk); rn = 1'b1;
    op(8, 32'h10, 32'h01, 1'b0, {1'b0, 32'h0F}, 1'b0, "t5_after_reset");

    // Random operations, back to back, checked against a wide arithmetic model
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rbv = $urandom; rbin = 1'($urandom_range(0, 1));
      e2 = {1'b0, ra[1:0]} - {1'b0, rbv[1:0]} - {2'b0, rbin};
      op(2, ra, rbv, rbin, {e2[2], 30'd0, e2[1:0]}, 1'b0, "t6_rand_w2");
    end
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rbv = $urandom; rbin = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 32'd0; rbv = 32'd0; rbin = 1'b1; end
      if (i == 1) begin ra = 32'hFFFF_FFFF; rbv = 32'hFFFF_FFFF; rbin = 1'b0; end
      e32 = {1'b0, ra} - {1'b0, rbv} - {32'd0, rbin};
      op(32, ra, rbv, rbin, e32, 1'b0, "t6_rand_w32");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
